// File: rtl/band_smpl_queue.sv
// Stereo sample window buffer: stores {left,right} samples and replays the newest READ_LEN, oldest first.
// Latency: a window-completing write at edge E gives the first replay sample after E+2, then READ_LEN consecutive samples.
// Backpressure: none; writes arriving while a replay is in progress are dropped.
module band_smpl_queue #(
  parameter int DEPTH    = 1024,
  parameter int READ_LEN = 1021
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt_smpl,
  input  logic [15:0] lft_smpl,
  input  logic [15:0] rght_smpl,
  output logic [15:0] lft_out,
  output logic [15:0] rght_out,
  output logic        sequencing
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(READ_LEN + 1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_LEN = CW'(READ_LEN);
  localparam logic [PW:0]   WIN_LEN = (PW+1)'(READ_LEN);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN} state_t;

  logic [31:0]   mem [DEPTH];
  state_t        state_q, state_d;
  logic [PW-1:0] new_ptr_q, new_ptr_d;
  logic [PW-1:0] old_ptr_q, old_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_en, rd_en;
  logic          rd_vld_q;
  logic [31:0]   rd_dat_q;
  logic [15:0]   lft_q, rght_q;
  logic          seq_q;
  logic [PW:0]   fill_after;

  // Occupancy the buffer would have once the sample on the inputs is stored.
  assign fill_after = {1'b0, new_ptr_q - old_ptr_q} + (PW+1)'(1);

  // Next-state and pointer updates; reset blocks the RAM write so a coincident sample is lost.
  always_comb begin
    state_d   = state_q;
    new_ptr_d = new_ptr_q;
    old_ptr_d = old_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (wrt_smpl && !rst) begin
          wr_en     = 1'b1;
          new_ptr_d = new_ptr_q + PTR_ONE;
          if (fill_after >= WIN_LEN) begin
            state_d  = ST_READ;
            rd_ptr_d = old_ptr_q;
            cnt_d    = CNT_LEN;
          end
        end
      end
      ST_READ: begin
        // Issue one address per cycle until the window is exhausted, then let the pipe empty.
        if (cnt_q != '0) begin
          rd_en    = 1'b1;
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          cnt_d    = cnt_q - CNT_ONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Retire the oldest sample so the next write slides the window by one.
        old_ptr_d = old_ptr_q + PTR_ONE;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      new_ptr_q <= '0;
      old_ptr_q <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      new_ptr_q <= new_ptr_d;
      old_ptr_q <= old_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rd_vld_q  <= rd_en;
    end
  end

  // Sample RAM: synchronous write and synchronous read, contents never cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[new_ptr_q] <= {lft_smpl, rght_smpl};
    end
    if (rd_en) begin
      rd_dat_q <= mem[rd_ptr_q];
    end
  end

  // Output register: loads only on valid read data, otherwise holds the last replayed sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      lft_q  <= '0;
      rght_q <= '0;
      seq_q  <= 1'b0;
    end else begin
      seq_q <= rd_vld_q;
      if (rd_vld_q) begin
        lft_q  <= rd_dat_q[31:16];
        rght_q <= rd_dat_q[15:0];
      end
    end
  end

  assign lft_out    = lft_q;
  assign rght_out   = rght_q;
  assign sequencing = seq_q;

endmodule

// File: tb/tb_band_smpl_queue.sv
// Bench for band_smpl_queue: a small instance (DEPTH 8, window 5) and a full-size instance.
// Expected replay windows come from a sliding-window model and are checked by negedge monitors.
module tb_band_smpl_queue;

  localparam int RL0 = 5;
  localparam int RL1 = 1021;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrt0, wrt1;
  logic [15:0] l0, r0, l1, r1;
  logic [15:0] lo0, ro0, lo1, ro1;
  logic        seq0, seq1;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] h0[$], h1[$], e0[$], e1[$];
  int          nok0 = 0, nok1 = 0;
  int          run0 = 0, run1 = 0;
  logic [31:0] hold0 = '0, hold1 = '0;
  logic [31:0] s0, s1;
  bit          mon_en = 1'b0;

  band_smpl_queue #(.DEPTH(8), .READ_LEN(RL0)) dut_small (
    .clk(clk), .rst(rst), .wrt_smpl(wrt0), .lft_smpl(l0), .rght_smpl(r0),
    .lft_out(lo0), .rght_out(ro0), .sequencing(seq0)
  );

  band_smpl_queue #(.DEPTH(1024), .READ_LEN(RL1)) dut_big (
    .clk(clk), .rst(rst), .wrt_smpl(wrt1), .lft_smpl(l1), .rght_smpl(r1),
    .lft_out(lo1), .rght_out(ro1), .sequencing(seq1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Sliding-window model: a write accepted at edge E joins the history; once the history
  // holds a full window the whole window is expected in order, the oldest entry retires,
  // and no further write is accepted before edge E+3+window.
  task automatic mdl_write(input bit big, input int e, input logic [31:0] s);
    if (!big) begin
      if (e >= nok0) begin
        h0.push_back(s);
        if (h0.size() >= RL0) begin
          foreach (h0[i]) e0.push_back(h0[i]);
          void'(h0.pop_front());
          nok0 = e + 3 + RL0;
        end
      end
    end else begin
      if (e >= nok1) begin
        h1.push_back(s);
        if (h1.size() >= RL1) begin
          foreach (h1[i]) e1.push_back(h1[i]);
          void'(h1.pop_front());
          nok1 = e + 3 + RL1;
        end
      end
    end
  endtask

  task automatic mdl_reset();
    h0.delete(); h1.delete(); e0.delete(); e1.delete();
    nok0 = 0; nok1 = 0; run0 = 0; run1 = 0;
    hold0 = '0; hold1 = '0;
  endtask

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input bit big, input logic [15:0] l, input logic [15:0] r);
    int e;
    e = cyc + 1;
    if (!big) begin wrt0 = 1'b1; l0 = l; r0 = r; end
    else      begin wrt1 = 1'b1; l1 = l; r1 = r; end
    @(posedge clk);
    #1;
    wrt0 = 1'b0;
    wrt1 = 1'b0;
    if (!rst) mdl_write(big, e, {l, r});
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mdl_reset();
  endtask

  task automatic wait_idle(input bit big);
    while (cyc + 1 < (big ? nok1 : nok0)) idle(1);
  endtask

  // Monitor, small instance.
  always @(negedge clk) begin
    if (mon_en) begin
      if (seq0) begin
        if (e0.size() == 0) chk("seq0_unexpected", 1, 0);
        else begin
          s0 = e0.pop_front();
          chk("lft0", $signed(lo0), $signed(s0[31:16]));
          chk("rght0", $signed(ro0), $signed(s0[15:0]));
          hold0 = s0;
        end
        run0++;
      end else begin
        chk("hold_lft0", $signed(lo0), $signed(hold0[31:16]));
        chk("hold_rght0", $signed(ro0), $signed(hold0[15:0]));
        if (run0 != 0) begin
          chk("burst_len0", run0, RL0);
          run0 = 0;
        end
      end
    end
  end

  // Monitor, full-size instance.
  always @(negedge clk) begin
    if (mon_en) begin
      if (seq1) begin
        if (e1.size() == 0) chk("seq1_unexpected", 1, 0);
        else begin
          s1 = e1.pop_front();
          chk("lft1", $signed(lo1), $signed(s1[31:16]));
          chk("rght1", $signed(ro1), $signed(s1[15:0]));
          hold1 = s1;
        end
        run1++;
      end else begin
        chk("hold_lft1", $signed(lo1), $signed(hold1[31:16]));
        chk("hold_rght1", $signed(ro1), $signed(hold1[15:0]));
        if (run1 != 0) begin
          chk("burst_len1", run1, RL1);
          run1 = 0;
        end
      end
    end
  end

  initial begin
    int k;
    logic [15:0] rl, rr;
    // Reset held two cycles with random inputs; writes coinciding with reset must be lost.
    rst = 1'b1; wrt1 = 1'b0; l1 = '0; r1 = '0;
    wrt0 = 1'($urandom_range(0, 1)); l0 = 16'($urandom); r0 = 16'($urandom);
    @(posedge clk);
    wrt0 = 1'b1; l0 = 16'($urandom); r0 = 16'($urandom);
    wrt1 = 1'b1; l1 = 16'($urandom); r1 = 16'($urandom);
    @(posedge clk);
    #1;
    rst = 1'b0; wrt0 = 1'b0; wrt1 = 1'b0;
    mdl_reset();
    @(negedge clk);
    chk("rst_lft0", int'(lo0), 0);
    chk("rst_rght0", int'(ro0), 0);
    chk("rst_seq0", int'(seq0), 0);
    chk("rst_lft1", int'(lo1), 0);
    chk("rst_rght1", int'(ro1), 0);
    chk("rst_seq1", int'(seq1), 0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Partial fill: no burst expected.
    for (int i = 1; i <= 4; i++) wr(1'b0, 16'(i), 16'(-i));
    idle(4);

    // First window, with explicit start latency checks.
    wr(1'b0, 16'(5), 16'(-5));
    @(negedge clk); chk("lat_e0", int'(seq0), 0);
    @(negedge clk); chk("lat_e1", int'(seq0), 0);
    @(negedge clk); chk("lat_e2", int'(seq0), 1);
    @(posedge clk);
    #1;
    wait_idle(1'b0);
    idle(3);

    // Slide across the pointer wrap.
    for (int i = 6; i <= 12; i++) begin
      wait_idle(1'b0);
      wr(1'b0, 16'(i), 16'(-i));
    end

    // Write during a burst is dropped.
    idle(3);
    wr(1'b0, 16'(99), 16'(-99));
    wait_idle(1'b0);
    wr(1'b0, 16'(13), 16'(-13));

    // Reset on the third burst cycle.
    wait_idle(1'b0);
    wr(1'b0, 16'(14), 16'(-14));
    idle(4);
    rst_pulse();
    @(negedge clk);
    chk("rstmid_seq", int'(seq0), 0);
    @(posedge clk);
    #1;
    for (int i = 20; i <= 24; i++) begin
      wait_idle(1'b0);
      wr(1'b0, 16'(i), 16'(-i));
    end

    // Random traffic including dropped writes and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      k  = $urandom_range(0, 99);
      rl = 16'($urandom);
      rr = 16'($urandom);
      if (k < 2)       rst_pulse();
      else if (k < 40) wr(1'b0, rl, rr);
      else             idle(1);
    end
    wait_idle(1'b0);
    idle(3);

    // Full-size instance: ramp fill, one full window, then one slide.
    for (int i = 1; i <= RL1; i++) wr(1'b1, 16'(i), 16'(-i));
    wait_idle(1'b1);
    wr(1'b1, 16'(RL1 + 1), 16'(-(RL1 + 1)));
    wait_idle(1'b1);
    idle(5);

    chk("exp0_drained", e0.size(), 0);
    chk("exp1_drained", e1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got no completion expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule
